// File: rtl/mem_stage_ctrl_if.sv
// MM-stage bundle: EX/MM inputs, stall, data-memory handshake and write-back record.
// master = mem_stage_ctrl, slave = pipeline/memory environment.
interface mem_stage_ctrl_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    logic            valid_MM;
    logic [XLEN-1:0] alu_result_MM;
    logic [XLEN-1:0] pc_MM;
    logic [XLEN-1:0] R1_data_MM;
    logic [RW-1:0]   R3_addr_MM;
    logic            mem_rw_MM;
    logic [1:0]      R3_dcntrl_MM;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    logic            stall_MM;
    logic            wb_valid;
    logic            wb_en;
    logic [RW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            misalign;
    logic            mem_err;

    modport master (
        input  valid_MM, alu_result_MM, pc_MM, R1_data_MM, R3_addr_MM, mem_rw_MM, R3_dcntrl_MM,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output stall_MM, wb_valid, wb_en, wb_addr, wb_data, misalign, mem_err
    );

    modport slave (
        output valid_MM, alu_result_MM, pc_MM, R1_data_MM, R3_addr_MM, mem_rw_MM, R3_dcntrl_MM,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  stall_MM, wb_valid, wb_en, wb_addr, wb_data, misalign, mem_err
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data-memory load/store handshake, MM stall and registered WB record.
// Optional access timeout/abort enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    mem_stage_ctrl_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_dmem_req, w_req_nxt;
    logic            r_dmem_we, w_we_nxt;
    logic [XLEN-1:0] r_dmem_addr, w_addr_nxt;
    logic [XLEN-1:0] r_dmem_wdata, w_wdata_nxt;
    logic            r_wb_valid, w_wb_valid_nxt;
    logic            r_wb_en, w_wb_en_nxt;
    logic [RW-1:0]   r_wb_addr, w_wb_addr_nxt;
    logic [XLEN-1:0] r_wb_data, w_wb_data_nxt;
    logic            r_misalign, w_misalign_nxt;
    logic            w_stall;

    logic w_is_store, w_is_load, w_misal;

    assign w_is_store = bus.valid_MM & bus.mem_rw_MM;
    assign w_is_load  = bus.valid_MM & ~bus.mem_rw_MM & (bus.R3_dcntrl_MM == 2'b10);
    assign w_misal    = |bus.alu_result_MM[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_mem_err, w_mem_err_nxt;
    logic             w_timeout;

    // Counter is 0 throughout IDLE, so it starts from 0 on every entry to REQ.
    assign w_cnt_nxt = (r_state == ST_IDLE) ? '0 : r_cnt + CNT_W'(1);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_mem_err <= w_mem_err_nxt;
        end
    end

    assign bus.mem_err = r_mem_err;
`else
    assign bus.mem_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_en      <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dmem_req   <= w_req_nxt;
            r_dmem_we    <= w_we_nxt;
            r_dmem_addr  <= w_addr_nxt;
            r_dmem_wdata <= w_wdata_nxt;
            r_wb_valid   <= w_wb_valid_nxt;
            r_wb_en      <= w_wb_en_nxt;
            r_wb_addr    <= w_wb_addr_nxt;
            r_wb_data    <= w_wb_data_nxt;
            r_misalign   <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_dmem_req;
        w_we_nxt       = r_dmem_we;
        w_addr_nxt     = r_dmem_addr;
        w_wdata_nxt    = r_dmem_wdata;
        w_wb_valid_nxt = 1'b0;
        w_wb_en_nxt    = r_wb_en;
        w_wb_addr_nxt  = r_wb_addr;
        w_wb_data_nxt  = r_wb_data;
        w_misalign_nxt = 1'b0;
        w_stall        = 1'b0;
`ifdef MEM_TIMEOUT_EN
        w_mem_err_nxt  = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_is_store || w_is_load) begin
                    w_stall     = 1'b1;
                    w_state_nxt = ST_REQ;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = w_is_store;
                    w_addr_nxt  = {bus.alu_result_MM[XLEN-1:2], 2'b00};
                    w_wdata_nxt = bus.R1_data_MM;
                end else if (bus.valid_MM) begin
                    w_wb_valid_nxt = 1'b1;
                    w_wb_addr_nxt  = bus.R3_addr_MM;
                    w_wb_en_nxt    = (bus.R3_dcntrl_MM != 2'b00) && (bus.R3_addr_MM != '0);
                    case (bus.R3_dcntrl_MM)
                        2'b01:   w_wb_data_nxt = bus.alu_result_MM;
                        2'b11:   w_wb_data_nxt = bus.pc_MM + XLEN'(4);
                        default: w_wb_data_nxt = '0;
                    endcase
                end
            end

            ST_REQ: begin
                if (bus.dmem_gnt) begin
                    w_req_nxt = 1'b0;
                    if (r_dmem_we) begin
                        w_state_nxt    = ST_IDLE;
                        w_wb_valid_nxt = 1'b1;
                        w_wb_en_nxt    = 1'b0;
                        w_misalign_nxt = w_misal;
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = ST_WAIT_RD;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end

            // Read data arriving alongside the grant is ignored; only taken here.
            ST_WAIT_RD: begin
                if (bus.dmem_rvalid) begin
                    w_state_nxt    = ST_IDLE;
                    w_wb_valid_nxt = 1'b1;
                    w_wb_addr_nxt  = bus.R3_addr_MM;
                    w_wb_data_nxt  = bus.dmem_rdata;
                    w_wb_en_nxt    = (bus.R3_addr_MM != '0);
                    w_misalign_nxt = w_misal;
                end else begin
                    w_stall = 1'b1;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef MEM_TIMEOUT_EN
        // Abort only if the access would otherwise still be outstanding.
        if ((r_state != ST_IDLE) && (w_state_nxt != ST_IDLE) && w_timeout) begin
            w_state_nxt    = ST_IDLE;
            w_req_nxt      = 1'b0;
            w_wb_valid_nxt = 1'b1;
            w_wb_en_nxt    = 1'b0;
            w_misalign_nxt = w_misal;
            w_mem_err_nxt  = 1'b1;
            w_stall        = 1'b0;
        end
`endif
    end

    // Stall is combinational; reset forces it low so an aborted access releases upstream at once.
    assign bus.stall_MM   = w_stall & ~reset;
    assign bus.dmem_req   = r_dmem_req;
    assign bus.dmem_we    = r_dmem_we;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_wdata = r_dmem_wdata;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_en      = r_wb_en;
    assign bus.wb_addr    = r_wb_addr;
    assign bus.wb_data    = r_wb_data;
    assign bus.misalign   = r_misalign;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl; timeout section runs when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mem_stage_ctrl_if bus();

`ifdef MEM_TIMEOUT_EN
    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (.clk(clk), .reset(reset), .bus(bus));
`else
    mem_stage_ctrl u_dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.valid_MM      = 1'b0;
        bus.alu_result_MM = 32'h0;
        bus.pc_MM         = 32'h0;
        bus.R1_data_MM    = 32'h0;
        bus.R3_addr_MM    = 5'd0;
        bus.mem_rw_MM     = 1'b0;
        bus.R3_dcntrl_MM  = 2'b00;
        bus.dmem_gnt      = 1'b0;
        bus.dmem_rvalid   = 1'b0;
        bus.dmem_rdata    = 32'h0;

        // reset state
        #12;
        chk1("rst_req", bus.dmem_req, 1'b0);
        chk1("rst_we", bus.dmem_we, 1'b0);
        chk32("rst_addr", bus.dmem_addr, 32'h0);
        chk1("rst_stall", bus.stall_MM, 1'b0);
        chk1("rst_wbv", bus.wb_valid, 1'b0);
        chk1("rst_wben", bus.wb_en, 1'b0);
        chk32("rst_wbdata", bus.wb_data, 32'h0);
        chk1("rst_mis", bus.misalign, 1'b0);
        chk1("rst_err", bus.mem_err, 1'b0);
        reset = 1'b0;
        step();

        // non-memory ALU op
        bus.valid_MM = 1'b1; bus.mem_rw_MM = 1'b0; bus.R3_dcntrl_MM = 2'b01;
        bus.alu_result_MM = 32'h0000_1234; bus.R3_addr_MM = 5'd5; bus.pc_MM = 32'h40;
        #1;
        chk1("alu_stall", bus.stall_MM, 1'b0);
        step();
        chk1("alu_wbv", bus.wb_valid, 1'b1);
        chk1("alu_wben", bus.wb_en, 1'b1);
        chk32("alu_wbaddr", 32'(bus.wb_addr), 32'd5);
        chk32("alu_wbdata", bus.wb_data, 32'h0000_1234);
        chk1("alu_req", bus.dmem_req, 1'b0);
        bus.valid_MM = 1'b0;
        #1;
        chk1("idle_stall", bus.stall_MM, 1'b0);
        step();
        chk1("idle_wbv", bus.wb_valid, 1'b0);
        chk32("idle_wbdata_hold", bus.wb_data, 32'h0000_1234);

        // pc+4 with wrap, then R3=0, then dcntrl=00
        bus.valid_MM = 1'b1; bus.R3_dcntrl_MM = 2'b11; bus.pc_MM = 32'hFFFF_FFFC; bus.R3_addr_MM = 5'd1;
        step();
        chk1("pc4_wbv", bus.wb_valid, 1'b1);
        chk1("pc4_wben", bus.wb_en, 1'b1);
        chk32("pc4_wrap", bus.wb_data, 32'h0000_0000);
        bus.R3_addr_MM = 5'd0;
        step();
        chk1("r0_wbv", bus.wb_valid, 1'b1);
        chk1("r0_wben", bus.wb_en, 1'b0);
        bus.R3_dcntrl_MM = 2'b00; bus.R3_addr_MM = 5'd3; bus.alu_result_MM = 32'h55;
        step();
        chk1("none_wben", bus.wb_en, 1'b0);
        chk32("none_wbdata", bus.wb_data, 32'h0);
        chk32("none_wbaddr", 32'(bus.wb_addr), 32'd3);
        bus.valid_MM = 1'b0;
        step();

        // store with grant delayed 3 cycles
        bus.valid_MM = 1'b1; bus.mem_rw_MM = 1'b1; bus.alu_result_MM = 32'h100;
        bus.R1_data_MM = 32'hDEAD_BEEF; bus.R3_dcntrl_MM = 2'b01; bus.R3_addr_MM = 5'd4;
        #1;
        chk1("st_idle_stall", bus.stall_MM, 1'b1);
        step();
        chk1("st_req_wbv", bus.wb_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.dmem_gnt = 1'b1;
            #1;
            chk1("st_req", bus.dmem_req, 1'b1);
            chk1("st_we", bus.dmem_we, 1'b1);
            chk32("st_addr", bus.dmem_addr, 32'h100);
            chk32("st_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
            chk1("st_stall", bus.stall_MM, (i != 2));
            step();
        end
        chk1("st_done_req", bus.dmem_req, 1'b0);
        chk1("st_done_wbv", bus.wb_valid, 1'b1);
        chk1("st_done_wben", bus.wb_en, 1'b0);
        chk1("st_done_mis", bus.misalign, 1'b0);
        chk1("st_done_err", bus.mem_err, 1'b0);
        bus.dmem_gnt = 1'b0; bus.valid_MM = 1'b0; bus.mem_rw_MM = 1'b0;
        step();
        chk1("st_after_wbv", bus.wb_valid, 1'b0);

        // aligned load: gnt immediate (with spurious rvalid), rvalid 2 cycles later
        bus.valid_MM = 1'b1; bus.R3_dcntrl_MM = 2'b10; bus.alu_result_MM = 32'h204; bus.R3_addr_MM = 5'd7;
        #1;
        chk1("ld_idle_stall", bus.stall_MM, 1'b1);
        step();
        chk1("ld_req", bus.dmem_req, 1'b1);
        chk1("ld_we", bus.dmem_we, 1'b0);
        chk32("ld_addr", bus.dmem_addr, 32'h204);
        bus.dmem_gnt = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1111_1111;
        #1;
        chk1("ld_gnt_stall", bus.stall_MM, 1'b1);
        step();
        chk1("ld_wait_req", bus.dmem_req, 1'b0);
        chk1("ld_wait_wbv", bus.wb_valid, 1'b0);
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        #1;
        chk1("ld_wait_stall", bus.stall_MM, 1'b1);
        step();
        chk1("ld_wait2_wbv", bus.wb_valid, 1'b0);
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
        #1;
        chk1("ld_rv_stall", bus.stall_MM, 1'b0);
        step();
        chk1("ld_wbv", bus.wb_valid, 1'b1);
        chk1("ld_wben", bus.wb_en, 1'b1);
        chk32("ld_wbaddr", 32'(bus.wb_addr), 32'd7);
        chk32("ld_wbdata", bus.wb_data, 32'hCAFE_F00D);
        chk1("ld_mis", bus.misalign, 1'b0);
        bus.dmem_rvalid = 1'b0; bus.valid_MM = 1'b0;
        step();
        chk1("ld_after_wbv", bus.wb_valid, 1'b0);

        // misaligned load to r0
        bus.valid_MM = 1'b1; bus.alu_result_MM = 32'h206; bus.R3_addr_MM = 5'd0;
        step();
        chk32("mis_addr", bus.dmem_addr, 32'h204);
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h0BAD_F00D;
        step();
        chk1("mis_wbv", bus.wb_valid, 1'b1);
        chk1("mis_wben", bus.wb_en, 1'b0);
        chk1("mis_flag", bus.misalign, 1'b1);
        chk32("mis_wbdata", bus.wb_data, 32'h0BAD_F00D);
        bus.dmem_rvalid = 1'b0; bus.valid_MM = 1'b0;
        step();
        chk1("mis_flag_clr", bus.misalign, 1'b0);

        // reset while in REQ
        bus.valid_MM = 1'b1; bus.alu_result_MM = 32'h300; bus.R3_addr_MM = 5'd9; bus.R3_dcntrl_MM = 2'b10;
        step();
        chk1("rreq_req_pre", bus.dmem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("rreq_req", bus.dmem_req, 1'b0);
        chk1("rreq_stall", bus.stall_MM, 1'b0);
        step();
        bus.valid_MM = 1'b0; reset = 1'b0;
        step();
        chk1("rreq_req_post", bus.dmem_req, 1'b0);
        chk1("rreq_wbv_post", bus.wb_valid, 1'b0);

        // reset while in WAIT_RD, late rvalid must not write back
        bus.valid_MM = 1'b1;
        step();
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        #2;
        chk1("rwait_stall_pre", bus.stall_MM, 1'b1);
        reset = 1'b1;
        #1;
        chk1("rwait_stall", bus.stall_MM, 1'b0);
        chk1("rwait_req", bus.dmem_req, 1'b0);
        chk1("rwait_wbv", bus.wb_valid, 1'b0);
        step();
        reset = 1'b0; bus.valid_MM = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEAD_DEAD;
        step();
        chk1("rwait_late_wbv", bus.wb_valid, 1'b0);
        chk32("rwait_late_wbdata", bus.wb_data, 32'h0);
        bus.dmem_rvalid = 1'b0;
        step();

`ifdef MEM_TIMEOUT_EN
        // store with grant never asserted: abort in 4th REQ cycle
        bus.valid_MM = 1'b1; bus.mem_rw_MM = 1'b1; bus.alu_result_MM = 32'h400; bus.R1_data_MM = 32'h1;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("to_req", bus.dmem_req, 1'b1);
            chk1("to_stall", bus.stall_MM, (i != 3));
            chk1("to_err_pre", bus.mem_err, 1'b0);
            step();
        end
        chk1("to_err", bus.mem_err, 1'b1);
        chk1("to_wbv", bus.wb_valid, 1'b1);
        chk1("to_wben", bus.wb_en, 1'b0);
        chk1("to_req_drop", bus.dmem_req, 1'b0);
        bus.valid_MM = 1'b0; bus.mem_rw_MM = 1'b0;
        step();
        chk1("to_err_clr", bus.mem_err, 1'b0);
        chk1("to_wbv_clr", bus.wb_valid, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage consumer of the EX/MM pipeline register.
- Takes the registered EX results, runs the data-memory load/store handshake, and produces the registered write-back record for the WB stage.
- Drives stall_MM back to the EX/MM register enable, holding it frozen while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT_RD before abort (only with MEM_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
valid_MM  input  1  MM stage holds a live instruction
alu_result_MM  input  32  ALU result; memory address for loads/stores
pc_MM  input  32  instruction PC
R1_data_MM  input  32  store data
R3_addr_MM  input  5  destination register
mem_rw_MM  input  1  1 = store, 0 = no store
R3_dcntrl_MM  input  2  write-back select: 00 none, 01 ALU, 10 load data, 11 pc_MM+4
dmem_req  output  1  memory request, registered
dmem_we  output  1  1 = write, registered
dmem_addr  output  32  {alu_result_MM[31:2],2'b00}, registered
dmem_wdata  output  32  store data, registered
dmem_gnt  input  1  request accepted this cycle
dmem_rvalid  input  1  read data valid this cycle
dmem_rdata  input  32  read data
stall_MM  output  1  combinational; 1 = upstream must hold
wb_valid  output  1  registered write-back record valid, 1-cycle pulse per instruction
wb_en  output  1  register-file write enable
wb_addr  output  5  destination register
wb_data  output  32  write-back data
misalign  output  1  registered; pulses with wb_valid when a memory op has address[1:0] != 0
mem_err  output  1  registered timeout pulse (0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset values: all outputs 0; FSM = IDLE. Reset asserted mid-access aborts it: req drops immediately and no wb_valid is produced for that instruction.
- Memory op classification:
  - Store: valid_MM & mem_rw_MM.
  - Load: valid_MM & !mem_rw_MM & R3_dcntrl_MM==10.
  - A store never writes back, regardless of R3_dcntrl_MM.
- Non-memory op in IDLE:
  - stall_MM=0.
  - Next edge: wb_valid=1, wb_addr=R3_addr_MM.
  - wb_data: 01 -> alu_result_MM; 11 -> pc_MM+4, mod 2^32; 00 -> 0.
  - wb_en=1 only if dcntrl!=00 and R3_addr_MM!=0.
- FSM states: IDLE, REQ, WAIT_RD.
  - IDLE + memory op: stall_MM=1; next edge -> REQ, dmem_req=1, dmem_we/addr/wdata loaded.
  - REQ: req/we/addr/wdata held stable until dmem_gnt=1.
    - Store with gnt: stall_MM=0; next edge -> IDLE, req=0, wb_valid=1, wb_en=0.
    - Load with gnt: stall_MM=1; next edge -> WAIT_RD, req=0.
    - No gnt: stall_MM=1.
  - WAIT_RD: stall_MM = !dmem_rvalid.
    - On rvalid: next edge -> IDLE, wb_valid=1, wb_data=dmem_rdata, wb_en=(R3_addr_MM!=0).
    - dmem_rvalid in the same cycle as gnt is ignored; data is taken in WAIT_RD only.
- Minimum latency: store 2 cycles in MM; load 3 cycles.
- wb_valid=0 in every cycle not listed above; wb_addr/wb_data hold their last values.
- valid_MM=0 in IDLE: no action, wb_valid=0.
- MM inputs must be stable while stall_MM=1; the block samples them live, not latched (except the dmem_* registers).
- Misaligned access still issues, using the word-aligned address; misalign pulses with the completing wb_valid.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 8+ bit counter clears on entry to REQ and counts each cycle in REQ/WAIT_RD.
  - On reaching TIMEOUT_CYCLES: next edge -> IDLE, req=0, wb_valid=1, wb_en=0, mem_err=1 for one cycle. stall_MM=0 in the abort cycle.
- Undefined: no counter, waits indefinitely, mem_err tied 0.

Test Plan:
- Non-memory op, valid_MM=1, dcntrl=01, alu=0x0000_1234, R3=5 -> next cycle wb_valid=1, wb_en=1, wb_addr=5, wb_data=0x1234; stall_MM never high.
- dcntrl=11, pc=0xFFFF_FFFC, R3=1 -> wb_data=0x0000_0000 (wrap); R3=0 -> wb_en=0.
- Store, addr 0x100, data 0xDEADBEEF, gnt delayed 3 cycles -> req/we/addr/wdata stable for 3 cycles; stall_MM high until gnt cycle; wb_valid=1 with wb_en=0.
- Load, addr 0x204, R3=7, gnt immediate, rvalid 2 cycles later with 0xCAFEF00D -> wb_data=0xCAFEF00D, wb_en=1; stall_MM low only in the rvalid cycle; addr 0x206 -> dmem_addr=0x204, misalign=1.
- Reset asserted while in WAIT_RD -> dmem_req, stall_MM, wb_valid all 0 immediately (asynchronous); FSM returns to IDLE; no late write-back when rvalid arrives after reset.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and gnt never asserted -> abort after 4 cycles in REQ: mem_err=1 and wb_valid=1 for one cycle, wb_en=0, req=0.
